// File: rtl/ide_sector_ctrl.sv
// IDE sector transfer sequencer: LBA load, READ/WRITE command, busy handshake, 512-byte data move.
// Optional status-poll timeout is compiled in when IDE_CTRL_TIMEOUT_EN is defined.
module ide_sector_ctrl #(
    parameter int STROBE_CYCLES = 2,
    parameter int SECTOR_BYTES  = 512,
    parameter int POLL_LIMIT    = 4096
) (
    input  logic                            clk_i,
    input  logic                            arst_i,
    input  logic                            start_i,
    input  logic                            dir_wr_i,
    input  logic [23:0]                     lba_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic                            ide_ce_n_o,
    output logic                            ide_oe_n_o,
    output logic                            ide_we_n_o,
    output logic [2:0]                      ide_addr_o,
    output logic [7:0]                      ide_wdata_o,
    input  logic [7:0]                      ide_rdata_i,
    output logic [$clog2(SECTOR_BYTES)-1:0] buf_addr_o,
    output logic                            buf_we_o,
    output logic [7:0]                      buf_wdata_o,
    input  logic [7:0]                      buf_rdata_i
);
    localparam int BA_W  = $clog2(SECTOR_BYTES);
    localparam int CNT_W = BA_W + 1;
    localparam int SC_W  = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LBA, S_CMD, S_WAIT_BSY, S_XFER, S_WAIT_RDY, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD
    } phase_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [SC_W-1:0]  stb_q, stb_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [23:0]      lba_q, lba_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic [2:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             acc_rd, xfer_wr, again;
`ifdef IDE_CTRL_TIMEOUT_EN
    localparam int PC_W = $clog2(POLL_LIMIT + 1);
    logic             error_q, error_d;
    logic [PC_W-1:0]  poll_q, poll_d;
`endif

    function automatic logic [2:0] reg_sel(input state_t s, input logic [1:0] i);
        case (s)
            S_LBA:   reg_sel = 3'd3 + {1'b0, i};
            S_XFER:  reg_sel = 3'd0;
            default: reg_sel = 3'd7;
        endcase
    endfunction

    function automatic logic [7:0] reg_wdata(input state_t s, input logic [1:0] i,
                                             input logic [23:0] l, input logic d);
        reg_wdata = 8'h00;
        if (s == S_LBA) begin
            case (i)
                2'd0:    reg_wdata = l[7:0];
                2'd1:    reg_wdata = l[15:8];
                default: reg_wdata = l[23:16];
            endcase
        end else if (s == S_CMD) begin
            reg_wdata = d ? 8'h30 : 8'h20;
        end
    endfunction

    assign acc_rd  = (state_q == S_WAIT_BSY) || (state_q == S_WAIT_RDY) ||
                     ((state_q == S_XFER) && !dir_q);
    assign xfer_wr = (state_q == S_XFER) && dir_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        stb_d   = stb_q;
        idx_d   = idx_q;
        count_d = count_q;
        lba_d   = lba_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        again   = 1'b0;
`ifdef IDE_CTRL_TIMEOUT_EN
        error_d = error_q;
        poll_d  = poll_q;
`endif
        case (state_q)
            S_IDLE: if (start_i) begin
                lba_d   = lba_i;
                dir_d   = dir_wr_i;
                busy_d  = 1'b1;
                idx_d   = 2'd0;
                state_d = S_LBA;
`ifdef IDE_CTRL_TIMEOUT_EN
                error_d = 1'b0;
`endif
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        case (phase_q)
            PH_IDLE: if (state_q != S_IDLE && state_q != S_DONE) begin
                phase_d = PH_SETUP;
                addr_d  = reg_sel(state_q, idx_q);
                wdata_d = reg_wdata(state_q, idx_q, lba_q, dir_q);
            end
            PH_SETUP: begin
                phase_d = PH_STROBE;
                stb_d   = '0;
                if (xfer_wr) wdata_d = buf_rdata_i;
            end
            PH_STROBE: begin
                if (stb_q == SC_W'(STROBE_CYCLES - 1)) begin
                    phase_d = PH_HOLD;
                    if (acc_rd) rdata_d = ide_rdata_i;
                end else begin
                    stb_d = stb_q + SC_W'(1);
                end
            end
            PH_HOLD: begin
                phase_d = PH_IDLE;
                case (state_q)
                    S_LBA: begin
                        if (idx_q == 2'd2) state_d = S_CMD;
                        else begin
                            idx_d = idx_q + 2'd1;
                            again = 1'b1;
                        end
                    end
                    S_CMD: state_d = S_WAIT_BSY;
                    S_WAIT_BSY: begin
                        if (rdata_q[3]) begin
                            state_d = S_XFER;
                            count_d = '0;
                        end else again = 1'b1;
                    end
                    S_XFER: begin
                        if (count_q == CNT_W'(SECTOR_BYTES - 1)) state_d = S_WAIT_RDY;
                        else begin
                            count_d = count_q + CNT_W'(1);
                            again   = 1'b1;
                        end
                    end
                    S_WAIT_RDY: begin
                        if (!rdata_q[3]) state_d = S_DONE;
                        else again = 1'b1;
                    end
                    default: ;
                endcase
`ifdef IDE_CTRL_TIMEOUT_EN
                // A poll that missed its bit3 value counts toward the limit; the last one aborts
                if (again && (state_q == S_WAIT_BSY || state_q == S_WAIT_RDY)) begin
                    if (poll_q == PC_W'(POLL_LIMIT - 1)) begin
                        again   = 1'b0;
                        error_d = 1'b1;
                        state_d = S_DONE;
                        poll_d  = '0;
                    end else begin
                        poll_d = poll_q + PC_W'(1);
                    end
                end else if (state_d != state_q) begin
                    poll_d = '0;
                end
`endif
                // Back-to-back access within the same state: SETUP directly follows HOLD
                if (again) begin
                    phase_d = PH_SETUP;
                    addr_d  = reg_sel(state_d, idx_d);
                    wdata_d = reg_wdata(state_d, idx_d, lba_q, dir_q);
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            phase_q <= PH_IDLE;
            stb_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            lba_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef IDE_CTRL_TIMEOUT_EN
            error_q <= 1'b0;
            poll_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            stb_q   <= stb_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            lba_q   <= lba_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef IDE_CTRL_TIMEOUT_EN
            error_q <= error_d;
            poll_q  <= poll_d;
`endif
        end
    end

    // Bus strobes decode straight from the phase register so arst releases them at once
    assign ide_ce_n_o  = (phase_q == PH_IDLE);
    assign ide_oe_n_o  = !((phase_q == PH_STROBE) && acc_rd);
    assign ide_we_n_o  = !((phase_q == PH_STROBE) && !acc_rd);
    assign ide_addr_o  = addr_q;
    assign ide_wdata_o = (xfer_wr && phase_q == PH_SETUP) ? buf_rdata_i : wdata_q;

    // In write direction the next byte address is issued during HOLD to hide buffer latency
    assign buf_addr_o  = count_q[BA_W-1:0] + {{(BA_W-1){1'b0}}, (xfer_wr && phase_q == PH_HOLD)};
    assign buf_we_o    = (state_q == S_XFER) && !dir_q && (phase_q == PH_HOLD);
    assign buf_wdata_o = rdata_q;

    assign busy_o = busy_q;
    assign done_o = (state_q == S_DONE);
`ifdef IDE_CTRL_TIMEOUT_EN
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule
